// File: rtl/cache_req_arbiter.sv
// Two-port round-robin read arbiter in front of the L1/L2 cache.
// Keeps one request in flight and returns the registered cache result to the requesting port.
module cache_req_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  output logic                  p0_req_ready,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_resp_data,
  output logic                  p0_resp_l1_hit,
  output logic                  p0_resp_l2_hit,
  input  logic                  p1_req_valid,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_req_ready,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_resp_data,
  output logic                  p1_resp_l1_hit,
  output logic                  p1_resp_l2_hit,
  output logic                  cache_read,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  output logic [CNT_WIDTH-1:0]  l1_hit_cnt,
  output logic [CNT_WIDTH-1:0]  l2_hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic                  busy
);

  // state | meaning
  // IDLE  | arbitrate between valid requests, handshake with the winner
  // ISSUE | single-cycle read strobe to the cache
  // WAIT  | cache outputs valid; capture result and update statistics
  // RESP  | one-cycle response pulse to the owning port
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  owner_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  l1_q, l2_q;
  logic [CNT_WIDTH-1:0]  l1_cnt_q, l2_cnt_q, miss_cnt_q;
  logic                  grant0, grant1;

  // On contention the port that did not win last time gets the grant
  assign grant0 = p0_req_valid & (~p1_req_valid | last_grant_q);
  assign grant1 = p1_req_valid & (~p0_req_valid | ~last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 | grant1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    cache_read    = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        busy         = 1'b0;
        p0_req_ready = grant0;
        p1_req_ready = grant1;
      end
      ISSUE: cache_read = 1'b1;
      RESP: begin
        p0_resp_valid = ~owner_q;
        p1_resp_valid = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      l1_q         <= 1'b0;
      l2_q         <= 1'b0;
      l1_cnt_q     <= '0;
      l2_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && (grant0 | grant1)) begin
        addr_q       <= grant1 ? p1_req_addr : p0_req_addr;
        owner_q      <= grant1;
        last_grant_q <= grant1;
      end
      if (state_q == WAIT) begin
        data_q <= cache_read_data;
        l1_q   <= cache_l1_hit;
        l2_q   <= cache_l2_hit;
        // Exactly one counter per request, each saturating at all-ones
        if (cache_l1_hit) begin
          if (l1_cnt_q != '1) l1_cnt_q <= l1_cnt_q + 1'b1;
        end else if (cache_l2_hit) begin
          if (l2_cnt_q != '1) l2_cnt_q <= l2_cnt_q + 1'b1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  assign cache_addr     = addr_q;
  assign p0_resp_data   = data_q;
  assign p1_resp_data   = data_q;
  assign p0_resp_l1_hit = l1_q;
  assign p1_resp_l1_hit = l1_q;
  assign p0_resp_l2_hit = l2_q;
  assign p1_resp_l2_hit = l2_q;
  assign l1_hit_cnt     = l1_cnt_q;
  assign l2_hit_cnt     = l2_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Two-port request arbiter and sequencer in front of the two-level (L1/L2) cache system. It accepts read requests from two requesters (port 0 and port 1) over valid/ready handshakes and grants them round-robin. It issues one single-cycle `read` pulse to the cache per granted request, captures the registered cache outputs, and returns them to the owning port as a one-cycle response. It also keeps saturating L1-hit, L2-hit and miss counters for performance reporting.

## Interface
Parameters:
- ADDR_WIDTH, 11, request/cache address width
- DATA_WIDTH, 11, cache data width
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- p0_req_valid  in  1  port 0 request pending
- p0_req_addr  in  ADDR_WIDTH  port 0 read address
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_resp_valid  out  1  port 0 response pulse
- p0_resp_data  out  DATA_WIDTH  port 0 read data
- p0_resp_l1_hit, p0_resp_l2_hit  out  1 each  port 0 hit flags
- p1_*  (same six signals as port 0)  port 1 request/response
- cache_read  out  1  read strobe to cache
- cache_addr  out  ADDR_WIDTH  address to cache
- cache_read_data  in  DATA_WIDTH  cache registered read data
- cache_l1_hit, cache_l2_hit  in  1 each  cache registered hit flags
- l1_hit_cnt, l2_hit_cnt, miss_cnt  out  CNT_WIDTH each  statistics counters
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: if either `req_valid` is high, pick the winner.
  - Only one valid: that port wins.
  - Both valid: the port not equal to `last_grant` wins.
  - Winner's `req_ready` is driven combinationally high this cycle; the handshake completes at this edge.
  - At the edge, latch the address into `cache_addr`, latch the winner id into `owner` and `last_grant`, then go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: `cache_read`=1 for exactly this cycle, with `cache_addr` stable. Next state is WAIT.
- WAIT: `cache_read`=0. The cache outputs are valid. At the edge:
  - Capture `cache_read_data`, `cache_l1_hit` and `cache_l2_hit` into the response registers.
  - Update the counters: L1 hit → `l1_hit_cnt`++; otherwise L2 hit → `l2_hit_cnt`++; otherwise `miss_cnt`++. Exactly one counter increments per request.
  - Go to RESP.
- RESP: `owner`'s `resp_valid`=1 for one cycle. The other port's `resp_valid` stays 0. There is no back-pressure; requesters must sink the response. Next state is IDLE.
- `req_ready` is 0 outside IDLE; requests presented then simply wait. Requesters must hold `valid` and `addr` stable until `ready`.
- `resp_data` and the hit flags hold their last captured values between responses. Both ports' outputs show the same captured registers; only `resp_valid` is port-specific.
- Counters saturate at all-ones and never wrap.
- `cache_read` is never high outside ISSUE, so at most one request is in flight.

## Timing
- Reset values: `cache_read`=0, `cache_addr`=0, all `resp_valid`=0, `resp_data`=0, hit flags=0, all counters=0, `busy`=0, `last_grant`=1 (port 0 wins the first contention), `owner`=0.
- Latency: handshake at edge E0 → ISSUE in cycle E0–E1 → cache samples at E1 → WAIT captures at E2 → `resp_valid` high during E2–E3 → IDLE after E3.
- Throughput: one request per 4 cycles. A new handshake can occur in the first IDLE cycle after RESP.
- Asynchronous reset at any state aborts the in-flight request:
  - No response is produced.
  - Counters for that request are not updated.
  - Outputs return to reset values immediately.
- If a requester drops `valid` in the same cycle as arbitration, it is not granted; the grant goes to the other port if that port is valid.

## Test plan
- Cold read: p0 reads 0x040 after reset → `p0_resp_valid` 3 cycles after handshake, data 0x3F3, l1=0, l2=0, `miss_cnt`=1, `p1_resp_valid` stays 0.
- Repeat read: p0 reads 0x040 again → data 0x3F3, l1=1, `l1_hit_cnt`=1, `miss_cnt` unchanged; `cache_read` high for exactly 1 cycle per request.
- Contention: p0 and p1 held valid continuously with addresses 0x010/0x420 → grants alternate 0,1,0,1, each response routed to the correct port, `busy` low only for single IDLE cycles.
- Reset mid-flight: assert rst during WAIT → no `resp_valid` on either port, all counters 0, and the next p1 request is served normally.
- Saturation: with CNT_WIDTH=2, issue 5 cold misses to distinct sets → `miss_cnt` stops at 3.
